// File: rtl/dfii_init_sequencer_if.sv
// Wishbone classic write-only bus between the DDR3 init sequencer and the
// DFII CSR bank.
interface dfii_init_sequencer_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    input  wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    output wb_ack, wb_err
  );
endinterface

// File: rtl/dfii_init_sequencer.sv
// DDR3 bring-up sequencer: walks a fixed 31-step table of DFII CSR writes and
// delays as a Wishbone classic master, then hands the PHY to the controller.
module dfii_init_sequencer #(
  parameter logic [31:0] CSR_BASE       = 32'h0000_9000,
  parameter logic [13:0] MR0_DLLRST     = 14'h320,
  parameter logic [13:0] MR0_VAL        = 14'h220,
  parameter logic [13:0] MR1_VAL        = 14'h006,
  parameter logic [13:0] MR2_VAL        = 14'h200,
  parameter logic [13:0] MR3_VAL        = 14'h000,
  parameter int          TDLLK_CYCLES   = 600,
  parameter int          TZQINIT_CYCLES = 600,
  parameter int          CMD_GAP        = 4,
  parameter int          ACK_TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [4:0]            step,
  dfii_init_sequencer_if.master wb
);

  localparam int MAX_AB = (TDLLK_CYCLES > TZQINIT_CYCLES) ? TDLLK_CYCLES : TZQINIT_CYCLES;
  localparam int MAX_CD = (CMD_GAP > ACK_TIMEOUT) ? CMD_GAP : ACK_TIMEOUT;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC) + 1;

  localparam logic [4:0] OFF_CONTROL  = 5'h00;
  localparam logic [4:0] OFF_COMMAND  = 5'h04;
  localparam logic [4:0] OFF_STROBE   = 5'h08;
  localparam logic [4:0] OFF_ADDRESS  = 5'h0C;
  localparam logic [4:0] OFF_BADDRESS = 5'h10;
  localparam logic [4:0] LAST_STEP    = 5'd30;

  localparam logic [CW-1:0] GAP_M1 = CW'(CMD_GAP - 1);
  localparam logic [CW-1:0] TO_M1  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic          is_dly;
    logic [4:0]    off;
    logic [31:0]   data;
    logic [CW-1:0] dly;
  } entry_t;

  // Steps 4..23 are five identical MRS groups: ADDRESS, BADDRESS, COMMAND, STROBE.
  function automatic entry_t step_entry(input logic [4:0] s);
    entry_t     e;
    logic [4:0] rel;
    logic [13:0] mr;
    logic [2:0] ba;
    e   = '0;
    rel = s - 5'd4;
    case (rel[4:2])
      3'd0:    begin mr = MR2_VAL;    ba = 3'd2; end
      3'd1:    begin mr = MR3_VAL;    ba = 3'd3; end
      3'd2:    begin mr = MR1_VAL;    ba = 3'd1; end
      3'd3:    begin mr = MR0_DLLRST; ba = 3'd0; end
      default: begin mr = MR0_VAL;    ba = 3'd0; end
    endcase
    if (s >= 5'd4 && s <= 5'd23) begin
      case (rel[1:0])
        2'd0:    begin e.off = OFF_ADDRESS;  e.data = {18'd0, mr}; end
        2'd1:    begin e.off = OFF_BADDRESS; e.data = {29'd0, ba}; end
        2'd2:    begin e.off = OFF_COMMAND;  e.data = 32'h0F;      end
        default: begin e.off = OFF_STROBE;   e.data = 32'h01;      end
      endcase
    end else begin
      case (s)
        5'd0:    begin e.off = OFF_ADDRESS;  e.data = 32'h000; end
        5'd1:    begin e.off = OFF_BADDRESS; e.data = 32'h000; end
        5'd2:    begin e.off = OFF_CONTROL;  e.data = 32'h00C; end
        5'd3:    begin e.off = OFF_CONTROL;  e.data = 32'h00E; end
        5'd24:   begin e.is_dly = 1'b1; e.dly = CW'(TDLLK_CYCLES); end
        5'd25:   begin e.off = OFF_ADDRESS;  e.data = 32'h400; end
        5'd26:   begin e.off = OFF_BADDRESS; e.data = 32'h000; end
        5'd27:   begin e.off = OFF_COMMAND;  e.data = 32'h003; end
        5'd28:   begin e.off = OFF_STROBE;   e.data = 32'h001; end
        5'd29:   begin e.is_dly = 1'b1; e.dly = CW'(TZQINIT_CYCLES); end
        default: begin e.off = OFF_CONTROL;  e.data = 32'h001; end
      endcase
    end
    return e;
  endfunction

  function automatic logic [29:0] word_adr(input logic [4:0] off);
    return 30'((CSR_BASE + 32'(off)) >> 2);
  endfunction

  state_t        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic [29:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          adv;
  entry_t        ent;

  // State and datapath registers; reset drops the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: table walk, ack/timeout handling, gap and delay counting.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    adv     = 1'b0;
    ent     = step_entry(step_q);
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          step_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (ent.is_dly) begin
          if (ent.dly == '0) adv = 1'b1;
          else               state_d = S_DELAY;
        end else begin
          cyc_d   = 1'b1;
          adr_d   = word_adr(ent.off);
          dat_d   = ent.data;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // err wins over a simultaneous ack
        if (wb.wb_err || (!wb.wb_ack && cnt_q == TO_M1)) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ERROR;
        end else if (wb.wb_ack) begin
          cyc_d = 1'b0;
          if (ent.off == OFF_STROBE && CMD_GAP != 0) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_M1) adv = 1'b1;
        else                 cnt_d = cnt_q + 1'b1;
      end
      S_DELAY: begin
        if (cnt_q == ent.dly - 1'b1) adv = 1'b1;
        else                         cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (step_q == LAST_STEP) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        step_d  = step_q + 5'd1;
        state_d = S_ISSUE;
      end
    end
  end

  assign wb.wb_cyc   = cyc_q;
  assign wb.wb_stb   = cyc_q;
  assign wb.wb_we    = cyc_q;
  assign wb.wb_sel   = 4'hF;
  assign wb.wb_adr   = adr_q;
  assign wb.wb_dat_w = dat_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign step        = step_q;

endmodule

// File: tb/tb_dfii_init_sequencer.sv
// Bench for dfii_init_sequencer: Wishbone slave with random wait states,
// error/no-ack injection, and a write-list/idle-gap model of the init table.
module tb_dfii_init_sequencer;
  localparam int CMD_GAP = 4;
  localparam int TDLLK   = 600;
  localparam int TZQ     = 600;
  localparam int ACK_TO  = 255;
  localparam int BUDGET  = 6000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [4:0] step;

  dfii_init_sequencer_if bus();

  dfii_init_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .error (error),
    .step  (step),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // slave / monitor controls, driven from the main initial block
  int ws_max  = 0;
  bit ws_rand = 1'b0;
  int err_idx = -1;
  bit no_ack  = 1'b0;
  bit clr     = 1'b0;

  // monitor state
  int          nwr, nstart, hicnt, lowrun, unstable, cur_ws, wcnt;
  logic        prev_cyc;
  logic [29:0] prev_adr;
  logic [31:0] prev_dat;
  logic [29:0] adr_q[$];
  logic [31:0] dat_q[$];
  int          gap_q[$];

  // reference: expected write list and idle cycles preceding each write
  logic [29:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  int          exp_gap[$];
  int          pend_dly = 0;

  function automatic logic [29:0] wadr(input int off);
    return 30'((32'h0000_9000 + 32'(off)) >> 2);
  endfunction

  // Each write costs one issue cycle of idle bus; a STROBE is followed by
  // CMD_GAP idle cycles; a delay step adds its count plus its own issue cycle.
  task automatic mw(input int off, input int dat);
    int g;
    g = 1;
    if (exp_adr.size() > 0 && exp_adr[exp_adr.size()-1] == wadr(8)) g += CMD_GAP;
    if (pend_dly > 0) g += pend_dly + 1;
    pend_dly = 0;
    exp_adr.push_back(wadr(off));
    exp_dat.push_back(32'(dat));
    exp_gap.push_back(g);
  endtask

  task automatic build_model();
    int mrv[5] = '{'h200, 'h000, 'h006, 'h320, 'h220};
    int mba[5] = '{2, 3, 1, 0, 0};
    mw('hC, 0); mw('h10, 0); mw('h0, 'h0C); mw('h0, 'h0E);
    for (int m = 0; m < 5; m++) begin
      mw('hC, mrv[m]); mw('h10, mba[m]); mw('h4, 'h0F); mw('h8, 1);
    end
    pend_dly = TDLLK;
    mw('hC, 'h400); mw('h10, 0); mw('h4, 'h03); mw('h8, 1);
    pend_dly = TZQ;
    mw('h0, 'h01);
  endtask

  // Wishbone slave: registered ack after cur_ws wait states
  always @(posedge clk) begin
    bus.wb_ack <= 1'b0;
    bus.wb_err <= 1'b0;
    if (!bus.wb_cyc) wcnt <= 0;
    else if (rst_n && bus.wb_stb && !bus.wb_ack && !bus.wb_err) begin
      if (wcnt >= cur_ws) begin
        wcnt <= 0;
        if (!no_ack) begin
          if (nwr == err_idx) bus.wb_err <= 1'b1;
          else                bus.wb_ack <= 1'b1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Bus monitor: logs acked writes, idle gaps, hold stability
  always @(negedge clk) begin
    if (clr) begin
      adr_q.delete(); dat_q.delete(); gap_q.delete();
      nwr <= 0; nstart <= 0; hicnt <= 0; lowrun <= 0; unstable <= 0;
    end else if (!rst_n) begin
      prev_cyc <= 1'b0;
      lowrun   <= 0;
    end else begin
      if (bus.wb_cyc) begin
        if (!prev_cyc) begin
          gap_q.push_back(lowrun);
          nstart <= nstart + 1;
          hicnt  <= 1;
          cur_ws <= ws_rand ? int'($urandom_range(ws_max, 0)) : ws_max;
        end else begin
          hicnt <= hicnt + 1;
        end
        if ((prev_cyc && (bus.wb_adr !== prev_adr || bus.wb_dat_w !== prev_dat)) ||
            bus.wb_stb !== 1'b1 || bus.wb_we !== 1'b1 || bus.wb_sel !== 4'hF)
          unstable <= unstable + 1;
        if (bus.wb_ack || bus.wb_err) begin
          nwr <= nwr + 1;
          if (!bus.wb_err) begin
            adr_q.push_back(bus.wb_adr);
            dat_q.push_back(bus.wb_dat_w);
          end
        end
        lowrun <= 0;
      end else begin
        lowrun <= lowrun + 1;
      end
      prev_cyc <= bus.wb_cyc;
      prev_adr <= bus.wb_adr;
      prev_dat <= bus.wb_dat_w;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Waits for busy to fall; a stray start pulse at cycle restart_at must be ignored.
  task automatic wait_idle(input string tag, input int restart_at);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
      start = (c == restart_at);
    end
    start = 1'b0;
    chk({tag, " finished_in_budget"}, 64'(ok), 64'd1);
  endtask

  task automatic check_full_run(input string tag);
    chk({tag, " busy"},  64'(busy),  64'd0);
    chk({tag, " done"},  64'(done),  64'd1);
    chk({tag, " error"}, 64'(error), 64'd0);
    chk({tag, " step"},  64'(step),  64'd30);
    chk({tag, " nwrites"}, 64'(adr_q.size()), 64'(exp_adr.size()));
    chk({tag, " ntransfers"}, 64'(nstart), 64'(exp_adr.size()));
    chk({tag, " hold_stable"}, 64'(unstable), 64'd0);
    for (int i = 0; i < adr_q.size() && i < exp_adr.size(); i++) begin
      chk($sformatf("%s w%0d adr", tag, i), 64'(adr_q[i]), 64'(exp_adr[i]));
      chk($sformatf("%s w%0d dat", tag, i), 64'(dat_q[i]), 64'(exp_dat[i]));
    end
    for (int i = 1; i < gap_q.size() && i < exp_gap.size(); i++)
      chk($sformatf("%s gap%0d", tag, i), 64'(gap_q[i]), 64'(exp_gap[i]));
  endtask

  task automatic full_run(input string tag, input int wsm, input bit wsr);
    ws_max = wsm; ws_rand = wsr;
    clear_mon();
    pulse_start();
    wait_idle(tag, int'($urandom_range(900, 50)));
    check_full_run(tag);
  endtask

  initial begin
    build_model();

    // reset values
    #1;
    chk("rst busy",  64'(busy),  64'd0);
    chk("rst done",  64'(done),  64'd0);
    chk("rst error", 64'(error), 64'd0);
    chk("rst step",  64'(step),  64'd0);
    chk("rst cyc",   64'(bus.wb_cyc), 64'd0);
    chk("rst stb",   64'(bus.wb_stb), 64'd0);
    chk("rst adr",   64'(bus.wb_adr), 64'd0);
    chk("rst dat",   64'(bus.wb_dat_w), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    full_run("zero_wait", 0, 1'b0);
    full_run("wait3", 3, 1'b0);
    full_run("rand_wait", int'($urandom_range(5, 1)), 1'b1);

    // wb_err on the MR1 COMMAND write (step 14)
    ws_max = 0; ws_rand = 1'b0; err_idx = 14;
    clear_mon();
    pulse_start();
    wait_idle("err14", -1);
    chk("err14 error", 64'(error), 64'd1);
    chk("err14 busy",  64'(busy),  64'd0);
    chk("err14 done",  64'(done),  64'd0);
    chk("err14 step",  64'(step),  64'd14);
    chk("err14 cyc",   64'(bus.wb_cyc), 64'd0);
    chk("err14 acked", 64'(adr_q.size()), 64'd14);
    err_idx = -1;
    full_run("after_err", 1, 1'b1);

    // slave never acks: timeout on step 0
    no_ack = 1'b1;
    clear_mon();
    pulse_start();
    wait_idle("timeout", -1);
    chk("timeout error", 64'(error), 64'd1);
    chk("timeout step",  64'(step),  64'd0);
    chk("timeout stb_cycles", 64'(hicnt), 64'(ACK_TO));
    repeat (50) @(negedge clk);
    chk("timeout ntransfers", 64'(nstart), 64'd1);
    chk("timeout nwrites", 64'(adr_q.size()), 64'd0);
    no_ack = 1'b0;

    // reset asserted in the middle of the tDLLK delay
    begin
      bit hit;
      hit = 1'b0;
      clear_mon();
      pulse_start();
      for (int c = 0; c < BUDGET; c++) begin
        @(negedge clk);
        if (step == 5'd24) begin hit = 1'b1; break; end
      end
      chk("dly reached step24", 64'(hit), 64'd1);
      repeat ($urandom_range(400, 10)) @(negedge clk);
      chk("dly busy_before", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("dly rst busy",  64'(busy),  64'd0);
      chk("dly rst done",  64'(done),  64'd0);
      chk("dly rst error", 64'(error), 64'd0);
      chk("dly rst step",  64'(step),  64'd0);
      chk("dly rst cyc",   64'(bus.wb_cyc), 64'd0);
      chk("dly rst stb",   64'(bus.wb_stb), 64'd0);
      chk("dly rst adr",   64'(bus.wb_adr), 64'd0);
      chk("dly rst dat",   64'(bus.wb_dat_w), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("dly idle after rst", 64'(bus.wb_cyc | busy), 64'd0);
    end

    full_run("after_rst", 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
